// File: rtl/rf_arbiter.sv
// rf_arbiter: shares one register-file port set (two reads, one write)
// between the core datapath (requester 0) and the debug/loader port
// (requester 1) with round-robin arbitration. Read data captured on the
// acceptance edge is returned to the winner one cycle later.
//
// Optional feature: define RF_ARB_LOCK_EN to let a winner hold the grant
// with req_lock; without it req_lock is ignored and arbitration is pure
// round-robin.
module rf_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_we,
  input  logic [3:0]         req_rs1,
  input  logic [3:0]         req_rs2,
  input  logic [3:0]         req_rd,
  input  logic [2*WIDTH-1:0] req_wd,
  input  logic [1:0]         req_lock,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_rs1_data,
  output logic [WIDTH-1:0]   rsp_rs2_data,
  output logic               rf_we,
  output logic [WIDTH-1:0]   rf_wd,
  output logic [1:0]         rf_rs1,
  output logic [1:0]         rf_rs2,
  output logic [1:0]         rf_rd,
  input  logic [WIDTH-1:0]   rf_rs1_out,
  input  logic [WIDTH-1:0]   rf_rs2_out
);

  // Requester that won the most recent acceptance; reset to 1 so that
  // requester 0 wins the first tie.
  logic             last_grant_reg;
  logic [1:0]       rsp_valid_reg;
  logic [WIDTH-1:0] rsp_rs1_reg;
  logic [WIDTH-1:0] rsp_rs2_reg;

  logic grant_any;
  logic grant_idx;

  // Per-requester views of the packed request fields.
  logic [1:0]       rs1_f [2];
  logic [1:0]       rs2_f [2];
  logic [1:0]       rd_f  [2];
  logic [WIDTH-1:0] wd_f  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign rs1_f[gi]     = req_rs1[gi*2 +: 2];
      assign rs2_f[gi]     = req_rs2[gi*2 +: 2];
      assign rd_f[gi]      = req_rd[gi*2 +: 2];
      assign wd_f[gi]      = req_wd[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = grant_any & (grant_idx == 1'(gi));
    end
  endgenerate

`ifdef RF_ARB_LOCK_EN
  logic lock_valid_reg, lock_valid_next;
  logic lock_owner_reg, lock_owner_next;
  logic lock_active;

  // Lock holds only while the owner keeps req_lock high; dropping it frees
  // arbitration in that very cycle.
  assign lock_active = lock_valid_reg & req_lock[lock_owner_reg];

  // Take ownership on a locked acceptance, release when the owner lets go.
  always_comb begin
    lock_valid_next = lock_valid_reg;
    lock_owner_next = lock_owner_reg;
    if (grant_any) begin
      lock_valid_next = req_lock[grant_idx];
      lock_owner_next = grant_idx;
    end else if (!lock_active) begin
      lock_valid_next = 1'b0;
    end
  end

  // Lock owner register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_valid_reg <= 1'b0;
      lock_owner_reg <= 1'b0;
    end else begin
      lock_valid_reg <= lock_valid_next;
      lock_owner_reg <= lock_owner_next;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Round-robin grant: single requester wins outright, a tie goes to the
  // requester that did not win last; an active lock overrides both.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (&req_valid) begin
      grant_any = 1'b1;
      grant_idx = ~last_grant_reg;
    end else if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = 1'b0;
    end else if (req_valid[1]) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end
`ifdef RF_ARB_LOCK_EN
    if (lock_active) begin
      grant_any = req_valid[lock_owner_reg];
      grant_idx = lock_owner_reg;
    end
`endif
  end

  // Register-file port mux; everything is zero when nobody is granted.
  always_comb begin
    rf_we  = 1'b0;
    rf_wd  = '0;
    rf_rs1 = '0;
    rf_rs2 = '0;
    rf_rd  = '0;
    if (grant_any) begin
      rf_we  = req_we[grant_idx];
      rf_wd  = wd_f[grant_idx];
      rf_rs1 = rs1_f[grant_idx];
      rf_rs2 = rs2_f[grant_idx];
      rf_rd  = rd_f[grant_idx];
    end
  end

  // Arbitration history and response capture on the acceptance edge. The
  // read data is sampled before the write lands, so a same-request
  // read-after-write returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 2'b00;
      rsp_rs1_reg    <= '0;
      rsp_rs2_reg    <= '0;
    end else begin
      rsp_valid_reg <= req_ready;
      if (grant_any) begin
        last_grant_reg <= grant_idx;
        rsp_rs1_reg    <= rf_rs1_out;
        rsp_rs2_reg    <= rf_rs2_out;
      end
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rs1_data = rsp_rs1_reg;
  assign rsp_rs2_data = rsp_rs2_reg;

endmodule

// File: tb/tb_rf_arbiter.sv
// Testbench for rf_arbiter: a small behavioural register file hangs off the
// rf_* ports; a shadow copy of its contents predicts every response, which
// is queued at acceptance and compared when the response appears.
module tb_rf_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_we = '0;
  logic [3:0]       req_rs1 = '0;
  logic [3:0]       req_rs2 = '0;
  logic [3:0]       req_rd = '0;
  logic [2*WIDTH-1:0] req_wd = '0;
  logic [1:0]       req_lock = '0;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_rs1_data;
  logic [WIDTH-1:0] rsp_rs2_data;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wd;
  logic [1:0]       rf_rs1, rf_rs2, rf_rd;
  logic [WIDTH-1:0] rf_rs1_out, rf_rs2_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]       v;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
  } rsp_t;
  rsp_t sb[$];

  logic [WIDTH-1:0] sh_mem [4];
  logic [WIDTH-1:0] rf_mem [4];

  always #5 clk = ~clk;

  rf_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_wd(req_wd), .req_lock(req_lock), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .rf_we(rf_we), .rf_wd(rf_wd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_rs1_out(rf_rs1_out), .rf_rs2_out(rf_rs2_out)
  );

  // Behavioural register file: combinational read, R0 reads zero, write on edge.
  assign rf_rs1_out = (rf_rs1 == 2'd0) ? '0 : rf_mem[rf_rs1];
  assign rf_rs2_out = (rf_rs2 == 2'd0) ? '0 : rf_mem[rf_rs2];
  always @(posedge clk) begin
    if (rf_we && rf_rd != 2'd0) rf_mem[rf_rd] <= rf_wd;
  end

  task automatic idle();
    req_valid = '0; req_we = '0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; req_wd = '0; req_lock = '0;
  endtask

  // One cycle: drive, check grant and port mux mid-cycle, then check the
  // response that follows the edge against the scoreboard.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [3:0] rd, input logic [31:0] wd,
                      input logic [1:0] lk, input logic [1:0] exp_ready,
                      input string name);
    rsp_t e;
    int   s2, sw;
    logic             e_we;
    logic [1:0]       e_rs1, e_rs2, e_rd;
    logic [WIDTH-1:0] e_wd;
    req_valid = v; req_we = we; req_rs1 = rs1; req_rs2 = rs2;
    req_rd = rd; req_wd = wd; req_lock = lk;
    #4;
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL %s ready: got %b want %b", name, req_ready, exp_ready);
    end
    e_we = 1'b0; e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_wd = '0;
    if (exp_ready != 2'b00) begin
      s2 = exp_ready[1] ? 2 : 0;
      sw = exp_ready[1] ? WIDTH : 0;
      e_we  = exp_ready[1] ? we[1] : we[0];
      e_rs1 = rs1[s2 +: 2];
      e_rs2 = rs2[s2 +: 2];
      e_rd  = rd[s2 +: 2];
      e_wd  = wd[sw +: WIDTH];
    end
    vectors++;
    if ({rf_we, rf_rd, rf_rs1, rf_rs2, rf_wd} !== {e_we, e_rd, e_rs1, e_rs2, e_wd}) begin
      miscompares++;
      $display("FAIL %s rf_port: got we=%b rd=%0d rs1=%0d rs2=%0d wd=%h want we=%b rd=%0d rs1=%0d rs2=%0d wd=%h",
               name, rf_we, rf_rd, rf_rs1, rf_rs2, rf_wd, e_we, e_rd, e_rs1, e_rs2, e_wd);
    end
    if (exp_ready != 2'b00) begin
      e.v = exp_ready; e.d1 = sh_mem[e_rs1]; e.d2 = sh_mem[e_rs2];
      sb.push_back(e);
      if (e_we && e_rd != 2'd0) sh_mem[e_rd] = e_wd;
    end
    @(posedge clk); #1;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.v = 2'b00; e.d1 = '0; e.d2 = '0; end
    vectors++;
    if (rsp_valid !== e.v) begin
      miscompares++;
      $display("FAIL %s rsp_valid: got %b want %b", name, rsp_valid, e.v);
    end else if (e.v != 2'b00) begin
      vectors++;
      if (rsp_rs1_data !== e.d1 || rsp_rs2_data !== e.d2) begin
        miscompares++;
        $display("FAIL %s rsp_data: got %h/%h want %h/%h", name, rsp_rs1_data, rsp_rs2_data, e.d1, e.d2);
      end
    end
    $display("step %-14s valid=%b ready=%b rsp_valid=%b rs1=%h rs2=%h", name, v, req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data);
    idle();
  endtask

  task automatic apply_reset(input int cycles);
    idle();
    rst = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 2'b00 || rsp_rs1_data !== '0 || rsp_rs2_data !== '0) begin
        miscompares++;
        $display("FAIL reset rsp: got v=%b %h/%h want 00 0000/0000", rsp_valid, rsp_rs1_data, rsp_rs2_data);
      end
      vectors++;
      if (req_ready !== 2'b00 || {rf_we, rf_rd, rf_rs1, rf_rs2, rf_wd} !== '0) begin
        miscompares++;
        $display("FAIL reset ports: got ready=%b we=%b wd=%h want 00 0 0000", req_ready, rf_we, rf_wd);
      end
    end
    rst = 1'b1;
    $display("reset  done");
  endtask

  task automatic test_single();
    step(2'b01, 2'b00, 4'b0001, 4'b0010, 4'b0000, 32'h0, 2'b00, 2'b01, "single");
  endtask

  task automatic test_contention();
    apply_reset(2);
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b00,
           (i % 2 == 0) ? 2'b01 : 2'b10, "contention");
  endtask

  task automatic test_write_read();
    step(2'b10, 2'b10, 4'b0000, 4'b0000, 4'b1100, {16'h00AA, 16'h0}, 2'b00, 2'b10, "wr_r3");
    step(2'b10, 2'b00, 4'b1100, 4'b0100, 4'b0000, 32'h0, 2'b00, 2'b10, "rd_r3");
    step(2'b01, 2'b01, 4'b0000, 4'b0000, 4'b0000, {16'h0, 16'hFFFF}, 2'b00, 2'b01, "wr_r0");
    step(2'b01, 2'b00, 4'b0000, 4'b0011, 4'b0000, 32'h0, 2'b00, 2'b01, "rd_r0");
  endtask

  task automatic test_hazard();
    step(2'b01, 2'b01, 4'b0000, 4'b0000, 4'b0010, {16'h0, 16'h0007}, 2'b00, 2'b01, "wr_r2_7");
    step(2'b01, 2'b01, 4'b0010, 4'b0001, 4'b0010, {16'h0, 16'h0009}, 2'b00, 2'b01, "hazard");
    step(2'b01, 2'b00, 4'b0010, 4'b0000, 4'b0000, 32'h0, 2'b00, 2'b01, "rd_r2_9");
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_rs1 = 4'b0001; req_rs2 = 4'b0010;
    #4;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_accept ready: got %b want 01", req_ready);
    end
    @(posedge clk); #1;
    idle();
    vectors++;
    if (rsp_valid !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_rsp_before: got %b want 01", rsp_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 2'b00 || rsp_rs1_data !== '0) begin
      miscompares++;
      $display("FAIL mid_rsp_dropped: got v=%b d=%h want 00 0000", rsp_valid, rsp_rs1_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    $display("reset_mid done");
    step(2'b11, 2'b00, 4'b0110, 4'b1001, 4'b0000, 32'h0, 2'b00, 2'b01, "post_rst_tie");
  endtask

  task automatic test_lock();
    apply_reset(2);
`ifdef RF_ARB_LOCK_EN
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b01, "lock_c1");
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b01, "lock_c2");
    step(2'b10, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b00, "lock_c3");
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b00, 2'b10, "lock_c4");
`else
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b01, "lock_c1");
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b10, "lock_c2");
    step(2'b10, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b01, 2'b10, "lock_c3");
    step(2'b11, 2'b00, 4'b1001, 4'b0110, 4'b0000, 32'h0, 2'b00, 2'b01, "lock_c4");
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sh_mem[i] = '0;
    apply_reset(2);
    @(posedge clk); #1;
    // Load R1=5, R2=8 through the arbiter before the checked reset.
    step(2'b01, 2'b01, 4'b0000, 4'b0000, 4'b0001, {16'h0, 16'h0005}, 2'b00, 2'b01, "load_r1");
    step(2'b01, 2'b01, 4'b0000, 4'b0000, 4'b0010, {16'h0, 16'h0008}, 2'b00, 2'b01, "load_r2");
    test_reset();
    test_single();
    test_contention();
    test_write_read();
    test_hazard();
    test_reset_mid();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
